seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Reads a multiplexed, active-low 7-segment display bus (segments plus per-digit anodes)
//  and converts it back into hexadecimal nibbles, one per digit.
//  It is the receive side of the display path: it snoops the display driver outputs for
//  self-check and debug readback.
//  A digit is accepted only after its anode/segment pattern has been stable for a programmable
//  number of cycles. Unknown patterns are flagged, not decoded.
// PARAMETERS
//  NDIG           4   number of multiplexed digits (1..8)
//  STABLE_CYCLES  4   consecutive identical samples required before capture (1..255)
// PORTS
//  clk        in   1        single clock, all logic rising-edge
//  rst        in   1        synchronous, active-high reset
//  seg        in   7        segment bus, active-low, bit0=a .. bit6=g (0 -> 7'b1000000)
//  an         in   NDIG     anode selects, active-low, bit i = digit i
//  clear      in   1        synchronous clear of captured state (same effect as rst)
//  digits     out  4*NDIG   decoded nibbles, digit i at [4i+3:4i]
//  dig_valid  out  NDIG     digit i holds a decoded hex value
//  dig_blank  out  NDIG     digit i last captured as 7'b1111111 (blank)
//  dig_err    out  NDIG     digit i last captured an undecodable pattern
//  update     out  1        1-cycle pulse: one digit's flags/value were written
//  frame_done out  1        1-cycle pulse: digit NDIG-1 captured valid and all dig_valid=1
// BEHAVIOUR
//  - Reset (rst, or clear): digits=0, dig_valid=0, dig_blank=0, dig_err=0, update=0,
//    frame_done=0, input sample regs=all-ones, stability counter=0, FSM=IDLE.
//    rst has priority over clear. If clear coincides with a capture, clear wins: no update.
//  - Inputs are registered once (s_seg, s_an) before any use.
//  - A sample is "single" when exactly one bit of s_an is 0. Zero or several active anodes:
//    the sample is ignored and the FSM goes to IDLE.
//  - FSM states:
//      IDLE:  counter=0. Go to TRACK when the sample is single.
//      TRACK: if s_seg/s_an equals the previous sample, counter++. Otherwise counter restarts
//             at 1 on the new single sample.
//             When the counter reaches STABLE_CYCLES, go to HOLD and capture.
//      HOLD:  no further capture. Any change of s_seg or s_an goes to TRACK (counter=1)
//             if the new sample is single, else to IDLE.
//  - Capture latency: a pattern applied at edge N and held is captured at edge
//    N+STABLE_CYCLES+1 (flags visible after it). update is high for that one cycle.
//  - Decode on capture, digit i = index of the active anode (the inverse of the display
//    encoding):
//      40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9 08->A 03->b 46->C 21->d
//      06->E 0E->F (hex, 7-bit)
//      decoded: nibble written, valid=1, blank=0, err=0
//      7F:      nibble kept, valid=0, blank=1, err=0
//      other:   nibble kept, valid=0, blank=0, err=1
//  - frame_done is registered in the same cycle as update when i==NDIG-1, the capture is
//    valid, and all other dig_valid bits are already 1.
//  - Re-capturing a digit overwrites only that digit's fields. Other digits are untouched.
//  - The counter saturates at STABLE_CYCLES. It has no wrap-around for any held input.
// TESTING
//  1. rst held 2 cycles, an=4'b1111 -> all outputs 0, no update over 20 cycles.
//  2. an=4'b1110, seg=7'h30 held 4 cycles (STABLE_CYCLES=4) -> update once at edge 5;
//     digits[3:0]=3, dig_valid=4'b0001; holding 20 more cycles gives no second update.
//  3. Scan digits 0..3 with 1,2,3,F, 6 cycles each -> four update pulses;
//     digits=16'hF321; frame_done pulses with the digit-3 update only.
//  4. Pattern held only 3 cycles (glitch), then an=4'b1100 (two anodes) -> no update,
//     FSM IDLE, outputs unchanged.
//  5. digit 2 seg=7'h7F, then seg=7'h55 -> dig_blank[2]=1, then dig_err[2]=1 with blank
//     cleared; digits[11:8] unchanged; dig_valid[2]=0.
//  6. clear asserted on the capture edge of digit 0 -> no update; all flags 0 next cycle;
//     a subsequent stable pattern is captured normally.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers one hex nibble per digit,
// capturing a digit only after its anode/segment pattern has been stable long enough.
module seg_scan_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    input  logic                clear,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_valid,
    output logic [NDIG-1:0]     dig_blank,
    output logic [NDIG-1:0]     dig_err,
    output logic                update,
    output logic                frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [6:0]        sSeg_q, pSeg_q, pSeg_d;
    logic [NDIG-1:0]   sAn_q, pAn_q, pAn_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d, blank_q, blank_d, err_q, err_d;
    logic              update_q, update_d, frameDone_q, frameDone_d;

    logic              single, sameSample, capture, decOk;
    logic [3:0]        activeIdx, decNib;
    logic [NDIG-1:0]   otherValid;

    function automatic logic [4:0] decodeSeg(input logic [6:0] s);
        case (s)
            7'h40: decodeSeg = {1'b1, 4'h0};
            7'h79: decodeSeg = {1'b1, 4'h1};
            7'h24: decodeSeg = {1'b1, 4'h2};
            7'h30: decodeSeg = {1'b1, 4'h3};
            7'h19: decodeSeg = {1'b1, 4'h4};
            7'h12: decodeSeg = {1'b1, 4'h5};
            7'h02: decodeSeg = {1'b1, 4'h6};
            7'h78: decodeSeg = {1'b1, 4'h7};
            7'h00: decodeSeg = {1'b1, 4'h8};
            7'h10: decodeSeg = {1'b1, 4'h9};
            7'h08: decodeSeg = {1'b1, 4'hA};
            7'h03: decodeSeg = {1'b1, 4'hB};
            7'h46: decodeSeg = {1'b1, 4'hC};
            7'h21: decodeSeg = {1'b1, 4'hD};
            7'h06: decodeSeg = {1'b1, 4'hE};
            7'h0E: decodeSeg = {1'b1, 4'hF};
            default: decodeSeg = {1'b0, 4'h0};
        endcase
    endfunction

    // Classify the registered sample: exactly one active anode, and which one it is.
    always_comb begin
        single     = ($countones(~sAn_q) == 1);
        sameSample = (sSeg_q == pSeg_q) && (sAn_q == pAn_q);
        activeIdx  = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!sAn_q[i]) activeIdx = 4'(i);
        end
        {decOk, decNib} = decodeSeg(sSeg_q);
    end

    // Stability tracker; the counter saturates because capture moves us to HOLD at the limit.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pSeg_d  = pSeg_q;
        pAn_d   = pAn_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = 8'd0;
                if (single) begin
                    state_d = ST_TRACK;
                    count_d = 8'd1;
                    pSeg_d  = sSeg_q;
                    pAn_d   = sAn_q;
                end
            end
            ST_TRACK: begin
                if (!single) begin
                    state_d = ST_IDLE;
                    count_d = 8'd0;
                end else if (sameSample) begin
                    if (count_q == 8'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else begin
                    count_d = 8'd1;
                    pSeg_d  = sSeg_q;
                    pAn_d   = sAn_q;
                end
            end
            ST_HOLD: begin
                if (!sameSample) begin
                    if (single) begin
                        state_d = ST_TRACK;
                        count_d = 8'd1;
                        pSeg_d  = sSeg_q;
                        pAn_d   = sAn_q;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 8'd0;
            end
        endcase
    end

    // Capture writes only the active digit's fields; frame_done uses the pre-capture valid bits.
    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        blank_d    = blank_q;
        err_d      = err_q;
        update_d   = capture;
        otherValid = valid_q;
        otherValid[NDIG-1] = 1'b1;
        frameDone_d = capture && decOk && (activeIdx == 4'(NDIG-1)) && (&otherValid);
        for (int i = 0; i < NDIG; i++) begin
            if (capture && (activeIdx == 4'(i))) begin
                if (decOk) begin
                    digits_d[4*i +: 4] = decNib;
                    valid_d[i] = 1'b1;
                    blank_d[i] = 1'b0;
                    err_d[i]   = 1'b0;
                end else if (sSeg_q == 7'h7F) begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b1;
                    err_d[i]   = 1'b0;
                end else begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b0;
                    err_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sSeg_q      <= '1;
            sAn_q       <= '1;
            pSeg_q      <= '1;
            pAn_q       <= '1;
            state_q     <= ST_IDLE;
            count_q     <= 8'd0;
            digits_q    <= '0;
            valid_q     <= '0;
            blank_q     <= '0;
            err_q       <= '0;
            update_q    <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            sSeg_q      <= seg;
            sAn_q       <= an;
            pSeg_q      <= pSeg_d;
            pAn_q       <= pAn_d;
            state_q     <= state_d;
            count_q     <= count_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            update_q    <= update_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign digits     = digits_q;
    assign dig_valid  = valid_q;
    assign dig_blank  = blank_q;
    assign dig_err    = err_q;
    assign update     = update_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed stimulus for seg_scan_decoder, checked every cycle against
// a run-length based reference model of the capture rules.
module tb_seg_scan_decoder;

    localparam int NDIG = 4;
    localparam int STABLE = 4;

    logic              clk = 1'b0;
    logic              rst, clear;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dig_valid, dig_blank, dig_err;
    logic              update, frame_done;

    int checks = 0;
    int passes = 0;

    logic [6:0]        segTable [16];
    logic [6:0]        mSeg;
    logic [NDIG-1:0]   mAn;
    int                runLen;
    bit                runCaptured;
    logic [4*NDIG-1:0] expDigits;
    logic [NDIG-1:0]   expValid, expBlank, expErr;
    logic              expUpdate, expFrame;

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .clear(clear),
        .digits(digits), .dig_valid(dig_valid), .dig_blank(dig_blank),
        .dig_err(dig_err), .update(update), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // A capture happens once the registered sample, with one active anode, has stayed
    // identical for STABLE+1 consecutive edges, and only once per such run.
    task automatic modelStep();
        int zeros, idx, nib;
        bit found;
        expUpdate = 1'b0;
        expFrame  = 1'b0;
        if (rst || clear) begin
            expDigits = '0; expValid = '0; expBlank = '0; expErr = '0;
            mSeg = 7'h7F; mAn = '1; runLen = 1; runCaptured = 0;
        end else begin
            zeros = 0; idx = 0;
            for (int i = 0; i < NDIG; i++) if (mAn[i] == 1'b0) begin zeros++; idx = i; end
            if (zeros == 1 && runLen >= STABLE + 1 && !runCaptured) begin
                runCaptured = 1;
                expUpdate = 1'b1;
                found = 0; nib = 0;
                for (int k = 0; k < 16; k++) if (segTable[k] == mSeg) begin found = 1; nib = k; end
                if (found) begin
                    expFrame = (idx == NDIG - 1);
                    for (int i = 0; i < NDIG - 1; i++) if (!expValid[i]) expFrame = 1'b0;
                    expDigits[4*idx +: 4] = 4'(nib);
                    expValid[idx] = 1; expBlank[idx] = 0; expErr[idx] = 0;
                end else if (mSeg == 7'h7F) begin
                    expValid[idx] = 0; expBlank[idx] = 1; expErr[idx] = 0;
                end else begin
                    expValid[idx] = 0; expBlank[idx] = 0; expErr[idx] = 1;
                end
            end
            if (seg == mSeg && an == mAn) begin
                if (runLen < 1000) runLen++;
            end else begin
                runLen = 1;
                runCaptured = 0;
            end
            mSeg = seg;
            mAn  = an;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("digits", 64'(digits), 64'(expDigits));
        checkOutput("dig_valid", 64'(dig_valid), 64'(expValid));
        checkOutput("dig_blank", 64'(dig_blank), 64'(expBlank));
        checkOutput("dig_err", 64'(dig_err), 64'(expErr));
        checkOutput("update", 64'(update), 64'(expUpdate));
        checkOutput("frame_done", 64'(frame_done), 64'(expFrame));
    endtask

    task automatic applyStimulus(input logic [6:0] s, input logic [NDIG-1:0] a, input int cycles);
        seg = s;
        an  = a;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    initial begin
        logic [6:0]      rs;
        logic [NDIG-1:0] ra;
        int              pick;
        segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; clear = 1'b0; seg = 7'h7F; an = '1;
        tick(); tick();
        rst = 1'b0;
        applyStimulus(7'h7F, 4'b1111, 20);
        checkOutput("reset_update", 64'(update), 64'd0);

        applyStimulus(7'h30, 4'b1110, 25);
        checkOutput("single_digit0", 64'(digits[3:0]), 64'h3);
        checkOutput("single_valid", 64'(dig_valid), 64'b0001);

        applyStimulus(7'h79, 4'b1110, 6);
        applyStimulus(7'h24, 4'b1101, 6);
        applyStimulus(7'h30, 4'b1011, 6);
        applyStimulus(7'h0E, 4'b0111, 6);
        applyStimulus(7'h7F, 4'b1111, 3);
        checkOutput("scan_digits", 64'(digits), 64'hF321);
        checkOutput("scan_valid", 64'(dig_valid), 64'hF);

        applyStimulus(7'h40, 4'b1110, 3);
        applyStimulus(7'h40, 4'b1100, 5);
        checkOutput("glitch_digits", 64'(digits), 64'hF321);

        applyStimulus(7'h7F, 4'b1011, 8);
        checkOutput("blank_flag", 64'(dig_blank[2]), 64'd1);
        applyStimulus(7'h55, 4'b1011, 8);
        checkOutput("err_flag", 64'(dig_err[2]), 64'd1);
        checkOutput("err_blank", 64'(dig_blank[2]), 64'd0);
        checkOutput("err_nibble", 64'(digits[11:8]), 64'h3);
        checkOutput("err_valid", 64'(dig_valid[2]), 64'd0);

        applyStimulus(7'h7F, 4'b1111, 2);
        applyStimulus(7'h40, 4'b1110, 5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_update", 64'(update), 64'd0);
        checkOutput("clear_valid", 64'(dig_valid), 64'd0);
        applyStimulus(7'h40, 4'b1110, 10);
        checkOutput("after_clear_valid", 64'(dig_valid), 64'b0001);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70) begin
                ra = '1;
                ra[$urandom_range(0, NDIG - 1)] = 1'b0;
            end else if (pick < 85) ra = '1;
            else ra = NDIG'($urandom);
            pick = $urandom_range(0, 99);
            if (pick < 70) rs = segTable[$urandom_range(0, 15)];
            else if (pick < 80) rs = 7'h7F;
            else rs = 7'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                seg = rs; an = ra; clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            applyStimulus(rs, ra, $urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
